// File: rtl/oam_dma.sv
// OAM DMA initiator: a write to DMA_REG_ADDR copies NUM_BYTES bytes from {src, 8'h00} into OAM.
// Optional macro OAM_DMA_ECHO_MIRROR_EN folds echo-RAM sources (0xE000-0xFFFF) onto 0xC000-0xDFFF.
module oam_dma #(
    parameter int          CYCLES_PER_BYTE = 4,
    parameter int          NUM_BYTES       = 160,
    parameter logic [15:0] OAM_BASE        = 16'hFE00,
    parameter logic [15:0] DMA_REG_ADDR    = 16'hFF46
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    input  logic        reg_write_en,
    input  logic        reg_read_en,
    output logic [7:0]  reg_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_read_en,
    output logic        bus_write_en,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active
);

    localparam int SW = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    src_q, src_d;
    logic [7:0]    src_eff_d;
    logic [15:0]   bus_addr_q;
    logic [7:0]    bus_wdata_q;
    logic          bus_read_en_q, bus_write_en_q, dma_active_q;
    logic          trigger, last_sub, read_slot_d, write_slot_d;

    assign reg_rdata    = (reg_read_en && reg_addr == DMA_REG_ADDR) ? src_q : 8'hFF;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_read_en  = bus_read_en_q;
    assign bus_write_en = bus_write_en_q;
    assign dma_active   = dma_active_q;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        trigger  = reg_write_en && (reg_addr == DMA_REG_ADDR);
        last_sub = (sub_q == SW'(CYCLES_PER_BYTE - 1));
        state_d  = state_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        src_d    = src_q;
        if (trigger) begin
            // A register write restarts from any state, including the final sub-cycle.
            src_d   = reg_wdata;
            state_d = START;
            sub_d   = '0;
            idx_d   = 8'h00;
        end else begin
            case (state_q)
                START: begin
                    if (last_sub) begin
                        state_d = XFER;
                        sub_d   = '0;
                    end else begin
                        sub_d = sub_q + SW'(1);
                    end
                end
                XFER: begin
                    if (last_sub) begin
                        sub_d = '0;
                        if (idx_q == 8'(NUM_BYTES - 1)) begin
                            state_d = IDLE;
                            idx_d   = 8'h00;
                        end else begin
                            idx_d = idx_q + 8'h01;
                        end
                    end else begin
                        sub_d = sub_q + SW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef OAM_DMA_ECHO_MIRROR_EN
        src_eff_d = (src_d >= 8'hE0) ? (src_d - 8'h20) : src_d;
`else
        src_eff_d = src_d;
`endif
        read_slot_d  = (state_d == XFER) && (sub_d == SW'(0));
        write_slot_d = (state_d == XFER) && (sub_d == SW'(1));
    end

    // NOTE: outputs are registered from next-state, so strobes never follow reg_* combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sub_q          <= '0;
            idx_q          <= 8'h00;
            src_q          <= 8'hFF;
            bus_addr_q     <= 16'h0000;
            bus_wdata_q    <= 8'h00;
            bus_read_en_q  <= 1'b0;
            bus_write_en_q <= 1'b0;
            dma_active_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sub_q          <= sub_d;
            idx_q          <= idx_d;
            src_q          <= src_d;
            bus_read_en_q  <= read_slot_d;
            bus_write_en_q <= write_slot_d;
            dma_active_q   <= (state_d != IDLE);
            if (read_slot_d) begin
                bus_addr_q <= {src_eff_d, idx_d};
            end
            // The write slot always follows a read cycle, so bus_rdata here is the byte to copy.
            if (write_slot_d) begin
                bus_addr_q  <= OAM_BASE + {8'h00, idx_d};
                bus_wdata_q <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected bus transactions, a negedge monitor pops and compares.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_write_en, reg_read_en;
    logic [7:0]  reg_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_read_en, bus_write_en;
    logic [7:0]  bus_rdata;
    logic        dma_active;

    oam_dma dut (
        .clk          (clk),
        .reset        (reset),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_write_en (reg_write_en),
        .reg_read_en  (reg_read_en),
        .reg_rdata    (reg_rdata),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_read_en  (bus_read_en),
        .bus_write_en (bus_write_en),
        .bus_rdata    (bus_rdata),
        .dma_active   (dma_active)
    );

    always #5 clk = ~clk;

    // Model memory: byte at offset i of any page reads as i ^ 8'h5A.
    assign bus_rdata = bus_addr[7:0] ^ 8'h5A;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   trig_cyc = 0;
    int   first_read_cyc = -1;
    int   active_cnt = 0;
    int   writes_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] eff_src(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_MIRROR_EN
        return (s >= 8'hE0) ? (s - 8'h20) : s;
`else
        return s;
`endif
    endfunction

    // Monitor: every strobe cycle is matched against the head of the expected queue.
    always @(negedge clk) begin
        txn_t e;
        if (dma_active) active_cnt++;
        if (bus_read_en || bus_write_en) begin
            check("strobe_exclusive", 32'(bus_read_en & bus_write_en), 32'd0);
            if (bus_write_en)
                check("oam_range", 32'(bus_addr >= 16'hFE00 && bus_addr <= 16'hFE9F), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_txn: got wr=%0b addr %0h, none expected", bus_write_en, bus_addr);
            end else begin
                e = exp_q.pop_front();
                check("txn_kind", 32'(bus_write_en), 32'(e.wr));
                check("txn_addr", 32'(bus_addr), 32'(e.addr));
                if (bus_write_en) begin
                    check("txn_data", 32'(bus_wdata), 32'(e.data));
                    writes_seen++;
                end else if (first_read_cyc < 0) begin
                    first_read_cyc = cyc;
                end
            end
        end
    end

    task automatic trigger(input logic [7:0] v);
        @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 160; i++) begin
            exp_q.push_back('{wr: 1'b0, addr: {eff_src(v), 8'(i)}, data: 8'h00});
            exp_q.push_back('{wr: 1'b1, addr: 16'hFE00 + 16'(i), data: 8'(i) ^ 8'h5A});
        end
        reg_addr     = 16'hFF46;
        reg_wdata    = v;
        reg_write_en = 1'b1;
        @(posedge clk);
        #1;
        reg_write_en   = 1'b0;
        trig_cyc       = cyc;
        first_read_cyc = -1;
        active_cnt     = 0;
        writes_seen    = 0;
    endtask

    task automatic read_reg(input string name, input logic [15:0] a, input logic [7:0] exp);
        @(negedge clk);
        reg_addr    = a;
        reg_read_en = 1'b1;
        #1;
        check(name, 32'(reg_rdata), 32'(exp));
        reg_read_en = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (writes_seen < n && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("wait_writes_reached", 32'(writes_seen >= n), 32'd1);
    endtask

    task automatic wait_done_and_check(input string tag);
        int t = 0;
        while (dma_active && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check({tag, "_dma_done"}, 32'(dma_active), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_write_count"}, 32'(writes_seen), 32'd160);
        check({tag, "_active_cycles"}, 32'(active_cnt), 32'd644);
        // First read appears in the fifth cycle after the trigger edge.
        check({tag, "_first_read_latency"}, 32'(first_read_cyc - trig_cyc), 32'd4);
    endtask

    initial begin
        reset        = 1'b1;
        reg_addr     = 16'h0000;
        reg_wdata    = 8'h00;
        reg_write_en = 1'b0;
        reg_read_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_addr", 32'(bus_addr), 32'h0000);
        check("rst_bus_wdata", 32'(bus_wdata), 32'h00);
        check("rst_read_en", 32'(bus_read_en), 32'd0);
        check("rst_write_en", 32'(bus_write_en), 32'd0);
        check("rst_dma_active", 32'(dma_active), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        read_reg("rst_reg_read", 16'hFF46, 8'hFF);

        // Full transfer from 0xC100.
        trigger(8'hC1);
        check("active_after_trigger", 32'(dma_active), 32'd1);
        wait_done_and_check("c1");
        read_reg("reg_read_c1", 16'hFF46, 8'hC1);
        read_reg("reg_read_other_addr", 16'hFF47, 8'hFF);
        @(negedge clk);
        reg_addr = 16'hFF46;
        #1;
        check("reg_no_read_en", 32'(reg_rdata), 32'hFF);

        // Restart at byte 50: trigger lands in the last sub-cycle of byte 49.
        trigger(8'hC1);
        wait_writes(50);
        @(negedge clk);
        trigger(8'hD0);
        wait_done_and_check("restart");
        read_reg("reg_read_d0", 16'hFF46, 8'hD0);

        // Reset during the read cycle of byte 80.
        trigger(8'h12);
        wait_writes(80);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_read_en", 32'(bus_read_en), 32'd0);
        check("midrst_write_en", 32'(bus_write_en), 32'd0);
        check("midrst_dma_active", 32'(dma_active), 32'd0);
        check("midrst_bus_addr", 32'(bus_addr), 32'h0000);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        read_reg("midrst_reg_read", 16'hFF46, 8'hFF);
        repeat (10) @(negedge clk);

        // Echo-range source, then a restart in the final sub-cycle of the last byte.
        trigger(8'hE2);
        read_reg("reg_read_e2", 16'hFF46, 8'hE2);
        wait_writes(160);
        @(negedge clk);
        trigger(8'h03);
        check("last_sub_restart_active", 32'(dma_active), 32'd1);
        wait_done_and_check("last_sub");
        read_reg("reg_read_03", 16'hFF46, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
